// File: rtl/aes_pkg.sv
// Shared AES arithmetic: GF(2^8) helpers, forward/inverse S-box and round constants.
package aes_pkg;

  typedef logic [127:0] state_t;

  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return gmul(a, 8'h09);
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] a);
    return gmul(a, 8'h0b);
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] a);
    return gmul(a, 8'h0d);
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] a);
    return gmul(a, 8'h0e);
  endfunction

  // Multiplicative inverse as a^254 (zero maps to zero), squaring chain a^2..a^128.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gmul(a, a);
    acc = sq;
    for (int unsigned i = 0; i < 6; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] t;
    t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/inv_cipher_if.sv
// Bundle of the data/control signals that accompany an inv_cipher instance.
interface inv_cipher_if #(
  parameter int KEY_BITS = 256
);
  import aes_pkg::*;

  state_t              plaintext;
  logic [KEY_BITS-1:0] key;
  logic                enable;
  state_t              out;

  modport master (output plaintext, output key, output enable, input out);
  modport slave  (input plaintext, input key, input enable, output out);
endinterface

// File: rtl/inv_cipher_round.sv
// One combinational AES decryption round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
module inv_cipher_round
  import aes_pkg::*;
(
  input  state_t state,
  input  state_t round_key,
  input  logic   final_round,
  output state_t result
);

  logic [7:0] ark [16];

  always_comb begin
    result = '0;
    // Byte i sits in column i/4, row i%4; row r is rotated right by r columns.
    for (int unsigned i = 0; i < 16; i++) begin
      ark[i] = inv_sbox(state[127 - 8*(4*(((i/4) + 4 - (i%4)) % 4) + (i%4)) -: 8])
               ^ round_key[127 - 8*i -: 8];
    end
    for (int unsigned c = 0; c < 4; c++) begin
      if (final_round) begin
        for (int unsigned r = 0; r < 4; r++) begin
          result[127 - 8*(4*c + r) -: 8] = ark[4*c + r];
        end
      end else begin
        result[127 - 32*c -: 8] = mul14(ark[4*c]) ^ mul11(ark[4*c+1]) ^ mul13(ark[4*c+2]) ^ mul9(ark[4*c+3]);
        result[119 - 32*c -: 8] = mul9(ark[4*c])  ^ mul14(ark[4*c+1]) ^ mul11(ark[4*c+2]) ^ mul13(ark[4*c+3]);
        result[111 - 32*c -: 8] = mul13(ark[4*c]) ^ mul9(ark[4*c+1])  ^ mul14(ark[4*c+2]) ^ mul11(ark[4*c+3]);
        result[103 - 32*c -: 8] = mul11(ark[4*c]) ^ mul13(ark[4*c+1]) ^ mul9(ark[4*c+2])  ^ mul14(ark[4*c+3]);
      end
    end
  end

endmodule

// File: rtl/inv_cipher.sv
// Iterative AES-128/192/256 decryption core, one round per enabled clock.
module inv_cipher #(
  parameter int KEY_BITS = 256
) (
  input  logic [127:0]         plaintext,
  input  logic [KEY_BITS-1:0]  key,
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic [127:0]         out
);
  import aes_pkg::*;

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  typedef logic [NW-1:0][31:0] sched_t;

  logic [0:0]          fsm;
  logic [3:0]          round;
  logic [KEY_BITS-1:0] key_q;
  logic [KEY_BITS-1:0] key_src;
  state_t              state_q;
  state_t              round_key;
  state_t              round_out;
  sched_t              sched;
  logic [3:0]          rk_idx;

  function automatic sched_t expand(input logic [KEY_BITS-1:0] k);
    sched_t     w;
    logic [31:0] t;
    w = '0;
    for (int unsigned i = 0; i < NK; i++) begin
      w[i] = k[KEY_BITS - 1 - 32*i -: 32];
    end
    for (int unsigned i = NK; i < NW; i++) begin
      t = w[i-1];
      if (i % NK == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {RCON[i/NK - 1], 24'h0};
      end else if (NK > 6 && i % NK == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-NK] ^ t;
    end
    return w;
  endfunction

  // In IDLE the schedule is fed from the live key so the start edge already sees w[Nr].
  always_comb begin
    key_src   = (fsm == IDLE) ? key : key_q;
    sched     = expand(key_src);
    rk_idx    = (fsm == IDLE) ? 4'(NR) : round;
    round_key = {sched[4*rk_idx], sched[4*rk_idx + 1], sched[4*rk_idx + 2], sched[4*rk_idx + 3]};
  end

  inv_cipher_round u_round (
    .state       (state_q),
    .round_key   (round_key),
    .final_round (round == 4'd0),
    .result      (round_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm     <= IDLE;
      round   <= '0;
      key_q   <= '0;
      state_q <= '0;
      out     <= '0;
    end else if (enable) begin
      case (fsm)
        IDLE: begin
          key_q   <= key;
          state_q <= plaintext ^ round_key;
          round   <= 4'(NR - 1);
          fsm     <= RUN;
        end
        RUN: begin
          if (round == 4'd0) begin
            out <= round_out;
            fsm <= IDLE;
          end else begin
            state_q <= round_out;
            round   <= round - 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_cipher.sv
// Bench for inv_cipher at all three key sizes; reference is a forward AES model (decrypt(encrypt(p)) == p).
module tb_inv_cipher;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inv_cipher_if #(.KEY_BITS(128)) bus128 ();
  inv_cipher_if #(.KEY_BITS(192)) bus192 ();
  inv_cipher_if #(.KEY_BITS(256)) bus256 ();

  inv_cipher #(.KEY_BITS(128)) dut128 (
    .plaintext(bus128.plaintext), .key(bus128.key), .clk(clk), .reset(reset),
    .enable(bus128.enable), .out(bus128.out));
  inv_cipher #(.KEY_BITS(192)) dut192 (
    .plaintext(bus192.plaintext), .key(bus192.key), .clk(clk), .reset(reset),
    .enable(bus192.enable), .out(bus192.out));
  inv_cipher #(.KEY_BITS(256)) dut256 (
    .plaintext(bus256.plaintext), .key(bus256.key), .clk(clk), .reset(reset),
    .enable(bus256.enable), .out(bus256.out));

  int total = 0;
  int bad   = 0;
  logic [7:0] sb [256];

  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  // Forward S-box from the generator-3 walk of GF(2^8).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [255:0] key, input int nk);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[4*(((i/4) + (i%4)) % 4) + (i%4)]];
      for (int c = 0; c < 4; c++) begin
        if (rnd < nr) begin
          s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
          s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  function automatic logic [127:0] out_of(input int kb);
    case (kb)
      128:     return bus128.out;
      192:     return bus192.out;
      default: return bus256.out;
    endcase
  endfunction

  task automatic set_en(input int kb, input logic en);
    bus128.enable = en && (kb == 128);
    bus192.enable = en && (kb == 192);
    bus256.enable = en && (kb == 256);
  endtask

  task automatic drive(input int kb, input logic [127:0] pt, input logic [255:0] k, input logic en);
    bus128.plaintext = pt;
    bus192.plaintext = pt;
    bus256.plaintext = pt;
    bus128.key = k[255:128];
    bus192.key = k[255:64];
    bus256.key = k;
    set_en(kb, en);
  endtask

  // Starts a block, optionally scrambles inputs after the start edge and pauses enable,
  // checks out holds its old value until the final edge and then equals exp.
  task automatic run_block(input int kb, input logic [127:0] ct, input logic [255:0] k,
                           input logic [127:0] exp, input string name, input bit scramble,
                           input int pause_at, input int pause_len);
    int nr, last;
    logic [127:0] prev, got;
    logic en_next;
    nr   = kb/32 + 6;
    last = nr + 1 + pause_len;
    @(negedge clk);
    prev = out_of(kb);
    drive(kb, ct, k, 1'b1);
    for (int e = 1; e <= last; e++) begin
      @(negedge clk);
      got = out_of(kb);
      total++;
      if (e < last) begin
        if (got !== prev) begin
          bad++;
          $display("FAIL %s hold edge %0d: got %h want %h", name, e, got, prev);
        end
      end else if (got !== exp) begin
        bad++;
        $display("FAIL %s result edge %0d: got %h want %h", name, e, got, exp);
      end
      en_next = !((e + 1 > pause_at) && (e + 1 <= pause_at + pause_len)) && (e < last);
      if (scramble && e == 1) drive(kb, rand128(), rand256(), en_next);
      else set_en(kb, en_next);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, rand128(), rand256(), 1'b0);
    #1 reset = 1'b0;
    bus128.enable = 1'b1;
    bus192.enable = 1'b1;
    bus256.enable = 1'b1;
    #2;
    for (int j = 0; j < 3; j++) begin
      total++;
      if (out_of(128 + 64*j) !== '0) begin
        bad++;
        $display("FAIL reset_out kb=%0d: got %h want 0", 128 + 64*j, out_of(128 + 64*j));
      end
    end
    @(negedge clk);
    set_en(0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (bus256.out !== '0) begin
      bad++;
      $display("FAIL idle_hold: got %h want 0", bus256.out);
    end
  endtask

  task automatic test_fips();
    run_block(128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, FIPS_KEY, FIPS_PT, "fips128", 1'b0, 0, 0);
    run_block(192, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, FIPS_KEY, FIPS_PT, "fips192", 1'b0, 0, 0);
    run_block(256, 128'h8ea2b7ca516745bfeafc49904b496089, FIPS_KEY, FIPS_PT, "fips256", 1'b0, 0, 0);
  endtask

  task automatic test_random();
    logic [127:0] p;
    logic [255:0] k;
    for (int j = 0; j < 12; j++) begin
      int kb;
      kb = 128 + 64*(j % 3);
      p  = rand128();
      k  = rand256();
      run_block(kb, aes_encrypt(p, k, kb/32), k, p, "random", j[0], 0, 0);
    end
  endtask

  task automatic test_pause();
    run_block(256, 128'h8ea2b7ca516745bfeafc49904b496089, FIPS_KEY, FIPS_PT, "pause", 1'b1, 6, 5);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(256, 128'h8ea2b7ca516745bfeafc49904b496089, FIPS_KEY, 1'b1);
    repeat (7) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (bus256.out !== '0) begin
      bad++;
      $display("FAIL reset_mid_out: got %h want 0", bus256.out);
    end
    @(negedge clk);
    set_en(0, 1'b0);
    reset = 1'b1;
    run_block(256, 128'h8ea2b7ca516745bfeafc49904b496089, FIPS_KEY, FIPS_PT, "after_reset", 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [127:0] pa, pb, got;
    logic [255:0] ka, kb;
    int nr;
    nr = 10;
    pa = rand128();
    pb = rand128();
    ka = rand256();
    kb = rand256();
    @(negedge clk);
    drive(128, aes_encrypt(pa, ka, 4), ka, 1'b1);
    for (int e = 1; e <= 2*nr + 2; e++) begin
      @(negedge clk);
      got = out_of(128);
      if (e == nr + 1) begin
        total++;
        if (got !== pa) begin
          bad++;
          $display("FAIL b2b_first: got %h want %h", got, pa);
        end
        drive(128, aes_encrypt(pb, kb, 4), kb, 1'b1);
      end else if (e > nr + 1 && e < 2*nr + 2) begin
        total++;
        if (got !== pa) begin
          bad++;
          $display("FAIL b2b_hold edge %0d: got %h want %h", e, got, pa);
        end
        if (e == nr + 2) drive(128, rand128(), rand256(), 1'b1);
      end else if (e == 2*nr + 2) begin
        total++;
        if (got !== pb) begin
          bad++;
          $display("FAIL b2b_second: got %h want %h", got, pb);
        end
        set_en(0, 1'b0);
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_random();
    test_pause();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
